// File: rtl/dm9000a_ior.sv
// dm9000a_ior: performs one DM9000A register read as two bus phases, an index
// write (CMD=0, IOW# strobe) followed by a data read (CMD=1, IOR# strobe), and
// returns the captured data with a RunStart/RunEnd level handshake.
// Build option: define DM9000A_IOR_BYTE_MASK_EN to return only the low data
// byte zero-extended. Leave it undefined to return the full 16-bit bus.
module dm9000a_ior #(
   parameter int T_SETUP = 1,   // clocks CS/CMD/address stable before a strobe
   parameter int T_PULSE = 2,   // clocks each strobe is held low
   parameter int T_HOLD  = 1,   // clocks after strobe release before phase end
   parameter int T_GAP   = 2    // idle clocks between index and data phases
)(
   input  logic        iDm9000aClk,
   input  logic        iRst,
   input  logic        iRunStart,
   input  logic [15:0] iReg,
   input  logic [15:0] iData,
   output logic        oRunEnd,
   output logic [15:0] oReturnValue,
   output logic        oDm9000aCs_n,
   output logic        oDm9000aCmd,
   output logic        oDm9000aIor_n,
   output logic        oDm9000aIow_n,
   output logic [15:0] oData,
   output logic        oDataOe
);

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_IDX_SETUP,
      ST_IDX_PULSE,
      ST_IDX_HOLD,
      ST_GAP,
      ST_RD_SETUP,
      ST_RD_PULSE,
      ST_RD_HOLD,
      ST_DONE
   } state_t;

   // A zero timing parameter still yields a one-clock phase.
   localparam logic [3:0] L_SETUP = (T_SETUP == 0) ? 4'd1 : T_SETUP[3:0];
   localparam logic [3:0] L_PULSE = (T_PULSE == 0) ? 4'd1 : T_PULSE[3:0];
   localparam logic [3:0] L_HOLD  = (T_HOLD  == 0) ? 4'd1 : T_HOLD[3:0];
   localparam logic [3:0] L_GAP   = (T_GAP   == 0) ? 4'd1 : T_GAP[3:0];

   // Length of the phase being entered; idle states carry no count.
   function automatic logic [3:0] f_phase_len(input state_t s);
      case (s)
         ST_IDX_SETUP, ST_RD_SETUP: f_phase_len = L_SETUP;
         ST_IDX_PULSE, ST_RD_PULSE: f_phase_len = L_PULSE;
         ST_IDX_HOLD,  ST_RD_HOLD:  f_phase_len = L_HOLD;
         ST_GAP:                    f_phase_len = L_GAP;
         default:                   f_phase_len = 4'd0;
      endcase
   endfunction

   state_t      r_state;
   state_t      w_state_next;
   logic [3:0]  r_cnt;
   logic [3:0]  w_cnt_next;
   logic        w_last;
   logic        w_capture;
   logic        w_idx_phase;
   logic        w_rd_phase;
   logic [15:0] w_read_value;

   logic        r_run_end;
   logic [15:0] r_return_value;
   logic        r_cs_n;
   logic        r_cmd;
   logic        r_ior_n;
   logic        r_iow_n;
   logic [15:0] r_data;
   logic        r_data_oe;

`ifdef DM9000A_IOR_BYTE_MASK_EN
   assign w_read_value = {8'h00, iData[7:0]};
`else
   assign w_read_value = iData;
`endif

   // Final clock of the current phase.
   assign w_last = (r_cnt <= 4'd1);

   // Read data is taken on the last clock of the IOR# pulse unless aborting.
   assign w_capture = (r_state == ST_RD_PULSE) && iRunStart && w_last;

   // Next-state, phase counter and bus-phase decode of the state being entered.
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         ST_IDLE:      if (iRunStart) w_state_next = ST_IDX_SETUP;
         ST_IDX_SETUP: if (!iRunStart) w_state_next = ST_IDLE;
                       else if (w_last) w_state_next = ST_IDX_PULSE;
         ST_IDX_PULSE: if (!iRunStart) w_state_next = ST_IDLE;
                       else if (w_last) w_state_next = ST_IDX_HOLD;
         ST_IDX_HOLD:  if (!iRunStart) w_state_next = ST_IDLE;
                       else if (w_last) w_state_next = ST_GAP;
         ST_GAP:       if (!iRunStart) w_state_next = ST_IDLE;
                       else if (w_last) w_state_next = ST_RD_SETUP;
         ST_RD_SETUP:  if (!iRunStart) w_state_next = ST_IDLE;
                       else if (w_last) w_state_next = ST_RD_PULSE;
         ST_RD_PULSE:  if (!iRunStart) w_state_next = ST_IDLE;
                       else if (w_last) w_state_next = ST_RD_HOLD;
         ST_RD_HOLD:   if (!iRunStart) w_state_next = ST_IDLE;
                       else if (w_last) w_state_next = ST_DONE;
         ST_DONE:      if (!iRunStart) w_state_next = ST_IDLE;
         default:      w_state_next = ST_IDLE;
      endcase

      if (w_state_next != r_state)
         w_cnt_next = f_phase_len(w_state_next);
      else if (r_cnt != 4'd0)
         w_cnt_next = r_cnt - 4'd1;
      else
         w_cnt_next = r_cnt;

      w_idx_phase = (w_state_next == ST_IDX_SETUP) || (w_state_next == ST_IDX_PULSE) ||
                    (w_state_next == ST_IDX_HOLD);
      w_rd_phase  = (w_state_next == ST_RD_SETUP) || (w_state_next == ST_RD_PULSE) ||
                    (w_state_next == ST_RD_HOLD);
   end

   // State, counter and registered bus/handshake outputs.
   always_ff @(posedge iDm9000aClk) begin
      if (iRst) begin
         r_state        <= ST_IDLE;
         r_cnt          <= 4'd0;
         r_run_end      <= 1'b0;
         r_return_value <= 16'h0000;
         r_cs_n         <= 1'b1;
         r_cmd          <= 1'b0;
         r_ior_n        <= 1'b1;
         r_iow_n        <= 1'b1;
         r_data         <= 16'h0000;
         r_data_oe      <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_cnt     <= w_cnt_next;
         r_run_end <= (r_state == ST_DONE) && iRunStart;
         r_cs_n    <= !(w_idx_phase || w_rd_phase);
         r_cmd     <= w_rd_phase;
         r_iow_n   <= (w_state_next != ST_IDX_PULSE);
         r_ior_n   <= (w_state_next != ST_RD_PULSE);
         r_data_oe <= w_idx_phase;
         if ((r_state == ST_IDLE) && iRunStart)
            r_data <= iReg;
         if (w_capture)
            r_return_value <= w_read_value;
      end
   end

   assign oRunEnd       = r_run_end;
   assign oReturnValue  = r_return_value;
   assign oDm9000aCs_n  = r_cs_n;
   assign oDm9000aCmd   = r_cmd;
   assign oDm9000aIor_n = r_ior_n;
   assign oDm9000aIow_n = r_iow_n;
   assign oData         = r_data;
   assign oDataOe       = r_data_oe;

endmodule
